// File: rtl/keypad_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | keypad_pkg : shared types, 7-segment decode and parameter checks      |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package keypad_pkg;

  localparam int CODE_W   = 4;
  localparam int MAX_KEYS = 16;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high; lower-case b and d glyphs.
  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h00;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic bit params_legal(input int n_rows, input int n_cols, input int digits,
                                      input int scan_div, input int debounce,
                                      input int refresh_div);
    return (n_rows >= 2) && (n_rows <= 8) && (n_cols >= 2) && (n_cols <= 8) &&
           (n_rows * n_cols <= MAX_KEYS) && (digits >= 1) && (digits <= 8) &&
           (scan_div >= 4) && (debounce >= 2) && (refresh_div >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_seg_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hex_seg_mux : key-code shift buffer with multiplexed 7-seg refresh    |
// | Revision    : 1.0                                                     |
// +-----------------------------------------------------------------------+
module hex_seg_mux
  import keypad_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CODE_W-1:0] code,
  input  logic              clear,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FW = $clog2(REFRESH_DIV);

  logic [DIGITS-1:0][CODE_W-1:0] digits_q, digits_d;
  logic [FW-1:0]                 ref_q, ref_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [6:0]                    seg_q;
  logic [DIGITS-1:0]             dig_en_q;
  logic                          w_dwell_end;

  assign w_dwell_end = (ref_q == FW'(REFRESH_DIV - 1));

  always_comb begin
    digits_d = digits_q;
    ref_d    = w_dwell_end ? '0 : ref_q + 1'b1;
    idx_d    = idx_q;
    if (w_dwell_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    // Clear takes priority so a simultaneous push is discarded.
    if (clear) begin
      digits_d = '0;
    end else if (push) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        digits_d[i] = digits_q[i-1];
      end
      digits_d[0] = code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      dig_en_q <= '0;
    end else begin
      digits_q <= digits_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      seg_q    <= hex2seg(digits_q[idx_q]);
      dig_en_q <= DIGITS'(1) << idx_q;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_display.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | keypad_scan_display : matrix keypad scanner, debounce, hex display    |
// | Revision            : 1.0                                             |
// +-----------------------------------------------------------------------+
module keypad_scan_display
  import keypad_pkg::*;
#(
  parameter int N_ROWS      = 4,
  parameter int N_COLS      = 4,
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 16,
  parameter int DEBOUNCE    = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_ROWS-1:0] row_in,
  input  logic              clear,
  output logic [N_COLS-1:0] col_drv,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEBOUNCE + 1);

  if (!params_legal(N_ROWS, N_COLS, DIGITS, SCAN_DIV, DEBOUNCE, REFRESH_DIV)) begin : g_param_check
    $error("keypad_scan_display: illegal parameter combination");
  end

  logic [N_ROWS-1:0] sync1_q, sync2_q;
  logic [DW-1:0]     div_q, div_d;
  scan_state_t       state_q, state_d;
  logic [CW-1:0]     col_q, col_d, w_col_next;
  logic [RW-1:0]     cand_q, cand_d, w_low_row;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d, w_code;
  logic              w_tick, w_any_low, w_cand_low, w_push;

  // Decisions happen on the last cycle of each period, SCAN_DIV-1 cycles after
  // the column strobe moved, so the two synchronizer stages have settled.
  assign w_tick     = (div_q == DW'(SCAN_DIV - 1));
  assign div_d      = w_tick ? '0 : div_q + 1'b1;
  assign w_any_low  = ~&sync2_q;
  assign w_cand_low = ~sync2_q[cand_q];
  assign w_col_next = (col_q == CW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
  assign w_code     = CODE_W'(cand_q) * CODE_W'(N_COLS) + CODE_W'(col_q);

  always_comb begin
    w_low_row = '0;
    for (int i = N_ROWS - 1; i >= 0; i--) begin
      if (!sync2_q[i]) w_low_row = RW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    w_push      = 1'b0;
    if (w_tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (w_any_low) begin
            cand_d  = w_low_row;
            cnt_d   = NW'(1);
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = w_col_next;
          end
        end
        ST_DEBOUNCE: begin
          if (w_cand_low) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == NW'(DEBOUNCE - 1)) begin
              key_valid_d = 1'b1;
              key_code_d  = w_code;
              w_push      = 1'b1;
              state_d     = ST_HELD;
            end
          end else begin
            state_d = ST_SCAN;
            col_d   = w_col_next;
          end
        end
        ST_HELD: begin
          if (!w_cand_low) begin
            cnt_d   = NW'(1);
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!w_cand_low) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == NW'(DEBOUNCE - 1)) begin
              state_d = ST_SCAN;
              col_d   = w_col_next;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      div_q       <= '0;
      state_q     <= ST_SCAN;
      col_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      sync1_q     <= row_in;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign col_drv   = ~(N_COLS'(1) << col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

  hex_seg_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_hex_seg_mux (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_push),
    .code   (key_code_d),
    .clear  (clear),
    .seg    (seg),
    .dig_en (dig_en)
  );

endmodule
`default_nettype wire

// File: doc/keypad_scan_display.md
# keypad_scan_display

Parametrised matrix-keypad scanner with debounce, key-event output and a multiplexed multi-digit hex seven-segment display. It drives column strobes, samples row returns, and reports each debounced press once as a one-cycle event. The pressed code is also shifted into a digit buffer that is refreshed onto a common seven-segment bus. It sits between the board keypad/LED pins and the user logic that consumes key events.

## Interface
- N_ROWS, 4, keypad rows (2..8)
- N_COLS, 4, keypad columns (2..8); N_ROWS*N_COLS must be ≤ 16
- DIGITS, 4, display digits (1..8)
- SCAN_DIV, 16, clocks per column sample period (≥ 4)
- DEBOUNCE, 4, consecutive agreeing samples required for press and for release (≥ 2)
- REFRESH_DIV, 16, clocks per displayed digit (≥ 2)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- row_in  in  N_ROWS  row returns, active-low (pulled up), asynchronous to clk
- clear  in  1  synchronous clear of the display buffer
- col_drv  out  N_COLS  column strobe, active-low one-hot
- key_valid  out  1  one-cycle pulse per debounced press
- key_code  out  4  row*N_COLS + col of the last press
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dig_en  out  DIGITS  digit enable, active-high one-hot

## Operation
- row_in passes a 2-flop synchronizer. Decisions use only the synchronized value sampled on the last cycle of each SCAN_DIV period.
- Scan FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: the column counter advances each period, wrapping from N_COLS-1 to 0.
  - No row low → stay in SCAN, advance to the next column.
  - Any row low → freeze the column, capture the lowest-index low row as the candidate, set the count to 1, go to DEBOUNCE.
- DEBOUNCE: on each sample, check the candidate row.
  - Still low → increment the count. When the count reaches DEBOUNCE, pulse key_valid, load key_code, push into the buffer, go to HELD.
  - Otherwise → go to SCAN on the next column.
- HELD: the column stays frozen. The first sample with the candidate row high → count = 1, go to RELEASE. There is no auto-repeat.
- RELEASE:
  - Candidate row high → increment the count. At DEBOUNCE, go to SCAN on the next column.
  - Candidate row low → return to HELD.
- Other keys pressed during DEBOUNCE/HELD/RELEASE are ignored.
- Display buffer: DIGITS×4 bits.
  - A push shifts digit i into i+1, loads digit 0 with key_code, and drops the oldest digit.
  - clear zeroes the buffer. If clear and a push happen in the same cycle, clear wins and the code is not stored; key_valid and key_code still update.
- Refresh: a counter dwells REFRESH_DIV cycles per digit, and the digit index wraps from DIGITS-1 to 0.
  - seg = hex(buffer[idx]), dig_en = 1<<idx. Both are registered together.
  - hex values: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.

## Timing
- Reset values:
  - col_drv = ~1 (column 0 driven)
  - key_valid = 0, key_code = 0
  - buffer = 0, FSM = SCAN, all counters = 0
  - seg = 0, dig_en = 0
- First clock after reset release: seg = 3F, dig_en = 1.
- col_drv changes only on a period boundary. The sample is taken SCAN_DIV-1 cycles after the change, which absorbs synchronizer latency.
- Press latency: key_valid rises on the cycle after the DEBOUNCE-th consecutive low sample, so at least (DEBOUNCE-1)·SCAN_DIV+1 cycles after the first low sample.
- key_code is valid with key_valid and held until the next press.
- The buffer updates on the same edge as key_valid. The new digit reaches seg when its digit slot is next refreshed.
- rst_n assertion mid-press or mid-debounce aborts immediately to the reset values. A still-held key is detected afresh after reset.

## Structure
- Package keypad_pkg holds:
  - the scan-state enum
  - the 16-entry hex-to-segment constant function
  - the parameter-legality checks, a simulation-time error if N_ROWS*N_COLS > 16
- Sub-module hex_seg_mux holds the buffer, refresh counter, digit select and decode. Ports: clk, rst_n, push, code, clear, seg, dig_en.
- The top level holds the synchronizer, scan/debounce FSM and key outputs.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE=3, REFRESH_DIV=4, defaults otherwise.
- Reset release, no keys → col_drv cycles E,D,B,7 every 4 clocks. key_valid never pulses. seg/dig_en sequence 3F/1, 3F/2, 3F/4, 3F/8.
- Hold row 2 / col 1 for 40 clocks → exactly one key_valid, key_code=9. Digit 0 then shows 6F.
- 1-sample glitch on row 0 during col 3 → no key_valid; scanning resumes at col 0.
- Press codes 1,2,3,4,5 in turn, each with full release → buffer digits 3..0 = 2,3,4,5. Segments 5B,4F,66,6D on dig_en 8,4,2,1.
- Rows 1 and 3 low together on col 0 → key_code=4 only. Re-press before the release count completes → no second pulse.
- clear asserted on the key_valid cycle → key_valid=1 with the correct code, buffer all zero. Assert rst_n mid-DEBOUNCE → all outputs return to reset values.
